// File: rtl/scr1_tapc_gen2_if.sv
// JTAG pin and external scan-chain bundle for scr1_tapc_gen2.
// The slave side is the TAP controller; the master side is the board/chain environment.
interface scr1_tapc_gen2_if #(
    parameter int IR_WIDTH = 5,
    parameter int NUM_DR   = 4
);
    logic                tms_i;
    logic                tdi_i;
    logic                tdo_o;
    logic                tdo_en_o;
    logic [3:0]          state_o;
    logic [IR_WIDTH-1:0] ir_o;
    logic [NUM_DR-1:0]   dr_sel_o;
    logic                dr_capture_o;
    logic                dr_shift_o;
    logic                dr_update_o;
    logic                dr_tdi_o;
    logic [NUM_DR-1:0]   dr_tdo_i;
    logic                tlr_o;

    modport slave (
        input  tms_i, tdi_i, dr_tdo_i,
        output tdo_o, tdo_en_o, state_o, ir_o, dr_sel_o,
               dr_capture_o, dr_shift_o, dr_update_o, dr_tdi_o, tlr_o
    );

    modport master (
        output tms_i, tdi_i, dr_tdo_i,
        input  tdo_o, tdo_en_o, state_o, ir_o, dr_sel_o,
               dr_capture_o, dr_shift_o, dr_update_o, dr_tdi_o, tlr_o
    );
endinterface

// File: rtl/scr1_tapc_gen2.sv
// Parametrised IEEE 1149.1 TAP controller: 16-state FSM, IR, IDCODE, BYPASS and NUM_DR external chains.
// Optional build-ID DR enabled by defining SCR1_TAPC_BLD_ID_EN (value taken from `SCR1_BUILD_ID).
`ifdef SCR1_TAPC_BLD_ID_EN
`ifndef SCR1_BUILD_ID
`define SCR1_BUILD_ID 32'h5C71_B1D0
`endif
`endif

module scr1_tapc_gen2 #(
    parameter int          IR_WIDTH      = 5,
    parameter logic [31:0] IDCODE_VALUE  = 32'hC0D1DEB1,
    parameter int          NUM_DR        = 4,
    parameter int          INSTR_IDCODE  = 1,
    parameter int          INSTR_BLD_ID  = 2,
    parameter int          DR_BASE_INSTR = 'h10
) (
    input logic               clk,
    input logic               rst_n,
    scr1_tapc_gen2_if.slave   tap
);

    localparam logic [3:0] ST_RESET      = 4'd0;
    localparam logic [3:0] ST_IDLE       = 4'd1;
    localparam logic [3:0] ST_DR_SELECT  = 4'd2;
    localparam logic [3:0] ST_DR_CAPTURE = 4'd3;
    localparam logic [3:0] ST_DR_SHIFT   = 4'd4;
    localparam logic [3:0] ST_DR_EXIT1   = 4'd5;
    localparam logic [3:0] ST_DR_PAUSE   = 4'd6;
    localparam logic [3:0] ST_DR_EXIT2   = 4'd7;
    localparam logic [3:0] ST_DR_UPDATE  = 4'd8;
    localparam logic [3:0] ST_IR_SELECT  = 4'd9;
    localparam logic [3:0] ST_IR_CAPTURE = 4'd10;
    localparam logic [3:0] ST_IR_SHIFT   = 4'd11;
    localparam logic [3:0] ST_IR_EXIT1   = 4'd12;
    localparam logic [3:0] ST_IR_PAUSE   = 4'd13;
    localparam logic [3:0] ST_IR_EXIT2   = 4'd14;
    localparam logic [3:0] ST_IR_UPDATE  = 4'd15;

    localparam logic [IR_WIDTH-1:0] IDCODE_CODE  = IR_WIDTH'(INSTR_IDCODE);
    localparam logic [IR_WIDTH-1:0] BLD_ID_CODE  = IR_WIDTH'(INSTR_BLD_ID);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE_V = IR_WIDTH'(2'b01);

    logic [3:0]          state;
    logic [3:0]          next_state;
    logic [IR_WIDTH-1:0] ir;
    logic [IR_WIDTH-1:0] shift_ir;
    logic [31:0]         idcode_sr;
    logic                bypass;
    logic [NUM_DR-1:0]   dr_sel;
    logic                ext_sel;
    logic                idcode_sel;
    logic                bypass_sel;
    logic                tdo;

    // NOTE: rst_n is sampled only on the clk edge (synchronous reset), so it lives inside the
    // clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RESET;
        end else begin
            // NOTE: registered state uses non-blocking assignment so every flop samples
            // pre-edge values regardless of statement order.
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_RESET:      next_state = tap.tms_i ? ST_RESET      : ST_IDLE;
            ST_IDLE:       next_state = tap.tms_i ? ST_DR_SELECT  : ST_IDLE;
            ST_DR_SELECT:  next_state = tap.tms_i ? ST_IR_SELECT  : ST_DR_CAPTURE;
            ST_DR_CAPTURE: next_state = tap.tms_i ? ST_DR_EXIT1   : ST_DR_SHIFT;
            ST_DR_SHIFT:   next_state = tap.tms_i ? ST_DR_EXIT1   : ST_DR_SHIFT;
            ST_DR_EXIT1:   next_state = tap.tms_i ? ST_DR_UPDATE  : ST_DR_PAUSE;
            ST_DR_PAUSE:   next_state = tap.tms_i ? ST_DR_EXIT2   : ST_DR_PAUSE;
            ST_DR_EXIT2:   next_state = tap.tms_i ? ST_DR_UPDATE  : ST_DR_SHIFT;
            ST_DR_UPDATE:  next_state = tap.tms_i ? ST_DR_SELECT  : ST_IDLE;
            ST_IR_SELECT:  next_state = tap.tms_i ? ST_RESET      : ST_IR_CAPTURE;
            ST_IR_CAPTURE: next_state = tap.tms_i ? ST_IR_EXIT1   : ST_IR_SHIFT;
            ST_IR_SHIFT:   next_state = tap.tms_i ? ST_IR_EXIT1   : ST_IR_SHIFT;
            ST_IR_EXIT1:   next_state = tap.tms_i ? ST_IR_UPDATE  : ST_IR_PAUSE;
            ST_IR_PAUSE:   next_state = tap.tms_i ? ST_IR_EXIT2   : ST_IR_PAUSE;
            ST_IR_EXIT2:   next_state = tap.tms_i ? ST_IR_UPDATE  : ST_IR_SHIFT;
            ST_IR_UPDATE:  next_state = tap.tms_i ? ST_DR_SELECT  : ST_IDLE;
            default:       next_state = ST_RESET;
        endcase
    end

    // IR shift register: capture the fixed 01 pattern, shift LSB-first, hold elsewhere.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_ir <= '0;
        end else if (state == ST_IR_CAPTURE) begin
            shift_ir <= IR_CAPTURE_V;
        end else if (state == ST_IR_SHIFT) begin
            shift_ir <= {tap.tdi_i, shift_ir[IR_WIDTH-1:1]};
        end
    end

    // The active instruction only moves on IR_UPDATE, so chain selects stay stable during DR scans.
    always_ff @(posedge clk) begin
        if (!rst_n || state == ST_RESET) begin
            ir <= IDCODE_CODE;
        end else if (state == ST_IR_UPDATE) begin
            ir <= shift_ir;
        end
    end

    always_comb begin
        dr_sel = '0;
        for (int i = 0; i < NUM_DR; i++) begin
            dr_sel[i] = (ir == IR_WIDTH'(DR_BASE_INSTR + i));
        end
    end

    assign ext_sel    = |dr_sel;
    assign idcode_sel = (ir == IDCODE_CODE);

`ifdef SCR1_TAPC_BLD_ID_EN
    logic        bld_sel;
    logic [31:0] bld_sr;

    assign bld_sel    = (ir == BLD_ID_CODE);
    assign bypass_sel = !idcode_sel && !ext_sel && !bld_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bld_sr <= `SCR1_BUILD_ID;
        end else if (state == ST_DR_CAPTURE && bld_sel) begin
            bld_sr <= `SCR1_BUILD_ID;
        end else if (state == ST_DR_SHIFT && bld_sel) begin
            bld_sr <= {tap.tdi_i, bld_sr[31:1]};
        end
    end
`else
    // Without the build-ID register its code falls through to BYPASS like any unassigned code.
    assign bypass_sel = (ir == BLD_ID_CODE) || (!idcode_sel && !ext_sel);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idcode_sr <= IDCODE_VALUE;
        end else if (state == ST_DR_CAPTURE && idcode_sel) begin
            idcode_sr <= IDCODE_VALUE;
        end else if (state == ST_DR_SHIFT && idcode_sel) begin
            idcode_sr <= {tap.tdi_i, idcode_sr[31:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bypass <= 1'b0;
        end else if (state == ST_DR_CAPTURE && bypass_sel) begin
            bypass <= 1'b0;
        end else if (state == ST_DR_SHIFT && bypass_sel) begin
            bypass <= tap.tdi_i;
        end
    end

    // TDO is muxed from register outputs (and external chain outputs) only, never from tdi/tms.
    always_comb begin
        tdo = 1'b0;
        if (state == ST_IR_SHIFT) begin
            tdo = shift_ir[0];
        end else if (state == ST_DR_SHIFT) begin
            if (ext_sel) begin
                tdo = |(dr_sel & tap.dr_tdo_i);
            end else if (idcode_sel) begin
                tdo = idcode_sr[0];
`ifdef SCR1_TAPC_BLD_ID_EN
            end else if (bld_sel) begin
                tdo = bld_sr[0];
`endif
            end else begin
                tdo = bypass;
            end
        end
    end

    assign tap.tdo_o        = tdo;
    assign tap.tdo_en_o     = (state == ST_DR_SHIFT) || (state == ST_IR_SHIFT);
    assign tap.state_o      = state;
    assign tap.ir_o         = ir;
    assign tap.dr_sel_o     = dr_sel;
    assign tap.dr_capture_o = (state == ST_DR_CAPTURE) && ext_sel;
    assign tap.dr_shift_o   = (state == ST_DR_SHIFT)   && ext_sel;
    assign tap.dr_update_o  = (state == ST_DR_UPDATE)  && ext_sel;
    assign tap.dr_tdi_o     = tap.tdi_i;
    assign tap.tlr_o        = (state == ST_RESET);

endmodule

// File: tb/tb_scr1_tapc_gen2.sv
// Directed self-checking bench for scr1_tapc_gen2 (default parameters).
// Build-ID expectations follow SCR1_TAPC_BLD_ID_EN as seen by this file.
`ifdef SCR1_TAPC_BLD_ID_EN
`ifndef SCR1_BUILD_ID
`define SCR1_BUILD_ID 32'h5C71_B1D0
`endif
`endif

module tb_scr1_tapc_gen2;
    localparam int IR_W = 5;
    localparam int N_DR = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cnt_cap, cnt_shift, cnt_upd;

    scr1_tapc_gen2_if #(.IR_WIDTH(IR_W), .NUM_DR(N_DR)) tap ();

    scr1_tapc_gen2 #(.IR_WIDTH(IR_W), .NUM_DR(N_DR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tap   (tap.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One TCK cycle: drive tms/tdi, clock, then sample 1 time unit after the edge.
    task automatic tick(input logic tms, input logic tdi);
        tap.tms_i = tms;
        tap.tdi_i = tdi;
        @(posedge clk);
        #1;
        cnt_cap   += int'(tap.dr_capture_o);
        cnt_shift += int'(tap.dr_shift_o);
        cnt_upd   += int'(tap.dr_update_o);
    endtask

    // IR scan from IDLE back to IDLE; returns the bits seen on tdo during IR_SHIFT.
    task automatic ir_scan(input logic [IR_W-1:0] val, output logic [IR_W-1:0] cap);
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < IR_W; i++) begin
            cap[i] = tap.tdo_o;
            tick(i == IR_W - 1, val[i]);
        end
        tick(1, 0);
        tick(0, 0);
    endtask

    initial begin
        logic [IR_W-1:0] cap;
        logic [31:0]     word;
        logic [31:0]     pat;
        logic [31:0]     exp_bld;
        logic [3:0]      bp_in;
        logic [3:0]      bp_exp;
        logic [3:0]      ext_pat;
        int              en_cnt;

        rst_n = 1'b0;
        tap.tms_i = 1'b0;
        tap.tdi_i = 1'b0;
        tap.dr_tdo_i = '0;
        tick(0, 0); tick(1, 0);

        chk("rst_state",  32'(tap.state_o), 32'd0);
        chk("rst_ir",     32'(tap.ir_o), 32'd1);
        chk("rst_tlr",    32'(tap.tlr_o), 32'd1);
        chk("rst_tdo",    32'(tap.tdo_o), 32'd0);
        chk("rst_tdo_en", 32'(tap.tdo_en_o), 32'd0);
        chk("rst_dr_sel", 32'(tap.dr_sel_o), 32'd0);
        chk("rst_strobes", {29'd0, tap.dr_capture_o, tap.dr_shift_o, tap.dr_update_o}, 32'd0);

        rst_n = 1'b1;
        tick(1, 0);
        chk("tlr_hold", 32'(tap.state_o), 32'd0);
        tick(0, 0);
        chk("idle_state", 32'(tap.state_o), 32'd1);
        chk("idle_ir",    32'(tap.ir_o), 32'd1);
        chk("idle_tlr",   32'(tap.tlr_o), 32'd0);

        // IDLE -> DR_SELECT -> DR_CAPTURE -> DR_EXIT1 -> DR_PAUSE, then five tms=1.
        tick(1, 0); tick(0, 0); tick(1, 0); tick(0, 0);
        chk("dr_pause", 32'(tap.state_o), 32'd6);
        for (int i = 0; i < 5; i++) tick(1, 0);
        chk("five_tms_state", 32'(tap.state_o), 32'd0);
        chk("five_tms_tlr",   32'(tap.tlr_o), 32'd1);

        // IDCODE scan, 32 shifts with tdi=0.
        tick(0, 0); tick(1, 0); tick(0, 0);
        chk("dr_capture_state", 32'(tap.state_o), 32'd3);
        tick(0, 0);
        word = '0;
        en_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            word[i] = tap.tdo_o;
            en_cnt += int'(tap.tdo_en_o);
            tick(i == 31, 0);
        end
        chk("idcode_value", word, 32'hC0D1DEB1);
        chk("idcode_en_cycles", 32'(en_cnt), 32'd32);
        chk("exit1_tdo_en", 32'(tap.tdo_en_o), 32'd0);
        chk("exit1_tdo", 32'(tap.tdo_o), 32'd0);
        tick(1, 0);
        chk("idcode_no_update", 32'(tap.dr_update_o), 32'd0);
        tick(0, 0);

        // IR scan to external chain 1.
        ir_scan(5'h11, cap);
        chk("ir_capture_bits", 32'(cap), 32'h01);
        chk("ir_after_update", 32'(tap.ir_o), 32'h11);
        chk("dr_sel_chain1",   32'(tap.dr_sel_o), 32'b0010);

        // External DR scan on chain 1, 4 shifts.
        cnt_cap = 0; cnt_shift = 0; cnt_upd = 0;
        ext_pat = 4'b1011;
        tick(1, 0); tick(0, 0);
        chk("ext_capture", 32'(tap.dr_capture_o), 32'd1);
        tick(0, 1);
        for (int i = 0; i < 4; i++) begin
            tap.dr_tdo_i = {2'b00, ext_pat[i], ~ext_pat[i]};
            #1;
            chk("ext_tdo", 32'(tap.tdo_o), 32'(ext_pat[i]));
            chk("ext_dr_tdi", 32'(tap.dr_tdi_o), 32'(tap.tdi_i));
            tick(i == 3, ~tap.tdi_i);
        end
        tap.dr_tdo_i = '0;
        tick(1, 0);
        chk("ext_update", 32'(tap.dr_update_o), 32'd1);
        tick(0, 0);
        chk("ext_cap_count",   32'(cnt_cap),   32'd1);
        chk("ext_shift_count", 32'(cnt_shift), 32'd4);
        chk("ext_upd_count",   32'(cnt_upd),   32'd1);

        // BYPASS via all-ones.
        ir_scan(5'h1F, cap);
        chk("ir_bypass", 32'(tap.ir_o), 32'h1F);
        chk("bypass_dr_sel", 32'(tap.dr_sel_o), 32'd0);
        cnt_cap = 0; cnt_shift = 0; cnt_upd = 0;
        bp_in  = 4'b1101;   // tdi sequence 1,0,1,1 (LSB first)
        bp_exp = 4'b1010;   // tdo sequence 0,1,0,1 (LSB first)
        tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("bypass_tdo", 32'(tap.tdo_o), 32'(bp_exp[i]));
            tick(i == 3, bp_in[i]);
        end
        tick(1, 0); tick(0, 0);
        chk("bypass_strobes", 32'(cnt_cap + cnt_shift + cnt_upd), 32'd0);

        // Reset in the middle of an IR shift toward 5'h12.
        cnt_upd = 0;
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        tick(0, 0); tick(0, 1);
        chk("mid_ir_shift", 32'(tap.state_o), 32'd11);
        rst_n = 1'b0;
        tick(1, 0);
        chk("mid_rst_state", 32'(tap.state_o), 32'd0);
        chk("mid_rst_ir",    32'(tap.ir_o), 32'd1);
        chk("mid_rst_tdo",   32'(tap.tdo_o), 32'd0);
        rst_n = 1'b1;
        tick(0, 0);
        chk("mid_rst_idle_ir", 32'(tap.ir_o), 32'd1);
        chk("mid_rst_no_update", 32'(cnt_upd), 32'd0);

        // Build-ID code: real register when enabled, bypass otherwise.
        ir_scan(5'h02, cap);
        chk("ir_bld", 32'(tap.ir_o), 32'h02);
        pat = 32'hA5C3_0F69;
`ifdef SCR1_TAPC_BLD_ID_EN
        exp_bld = `SCR1_BUILD_ID;
`else
        exp_bld = {pat[30:0], 1'b0};
`endif
        tick(1, 0); tick(0, 0); tick(0, 0);
        word = '0;
        for (int i = 0; i < 32; i++) begin
            word[i] = tap.tdo_o;
            tick(i == 31, pat[i]);
        end
        tick(1, 0); tick(0, 0);
        chk("bld_scan", word, exp_bld);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/scr1_tapc_gen2.md
Name: scr1_tapc_gen2

Overview:
Parametrised IEEE 1149.1 TAP controller. Successor to the fixed 4-bit-IR TAPC: IR width, IDCODE value and number of external DR chains are set by parameter. It implements the 16-state TAP FSM, the IR, and internal IDCODE and BYPASS registers. Strobes and select lines drive NUM_DR external scan chains, such as DAP, debug status and system control.

Parameters:
IR_WIDTH, 5, instruction register width; legal range 4..8.
IDCODE_VALUE, 32'hC0D1DEB1, value captured by the IDCODE DR; bit 0 must be 1.
NUM_DR, 4, number of external DR chains; legal range 1..8.
INSTR_IDCODE, 1, IR code that selects the IDCODE DR.
INSTR_BLD_ID, 2, IR code that selects the build-ID DR (optional feature only).
DR_BASE_INSTR, 'h10, IR code of external chain 0; chain i uses DR_BASE_INSTR+i.

Ports:
clk  in  1  TCK; all state changes on the rising edge
rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
tms_i  in  1  test mode select
tdi_i  in  1  test data in
tdo_o  out  1  test data out; combinational from registers only, no path from tdi_i or tms_i
tdo_en_o  out  1  high while the FSM is in DR_SHIFT or IR_SHIFT
state_o  out  4  current FSM state; encoding RESET=0 … IR_UPDATE=15, standard ordering
ir_o  out  IR_WIDTH  current instruction
dr_sel_o  out  NUM_DR  one-hot external chain select, decoded from ir_o
dr_capture_o  out  1  high in the DR_CAPTURE state when an external chain is selected
dr_shift_o  out  1  high in the DR_SHIFT state when an external chain is selected
dr_update_o  out  1  high in the DR_UPDATE state when an external chain is selected
dr_tdi_o  out  1  equals tdi_i
dr_tdo_i  in  NUM_DR  serial output of each external chain
tlr_o  out  1  high while in the RESET state

Behaviour:
- Reset (rst_n low at a clk edge):
  - state goes to RESET; ir_o = INSTR_IDCODE; IR shift register = 0; IDCODE shift register = IDCODE_VALUE; bypass bit = 0.
  - Outputs after reset: dr_sel_o = 0, all strobes 0, tdo_en_o = 0, tlr_o = 1, tdo_o = 0.
  - Reset mid-shift discards partial shift data; ir_o is not updated.
- FSM:
  - Standard 1149.1 transitions on tms_i, one per clk.
  - RESET stays in RESET on tms=1 and goes to IDLE on tms=0.
  - Five consecutive tms=1 cycles reach RESET from any state.
  - While in RESET, ir_o is forced to INSTR_IDCODE every cycle.
- IR path:
  - IR_CAPTURE loads the IR shift register with {0…0, 2'b01}.
  - IR_SHIFT: each clk, shift_ir <= {tdi_i, shift_ir[IR_WIDTH-1:1]}; tdo_o = shift_ir[0].
  - IR_UPDATE: ir_o <= shift_ir. The new value is visible the cycle after the IR_UPDATE state.
  - PAUSE and EXIT states hold the shift register.
- Instruction decode:
  - INSTR_IDCODE selects the 32-bit IDCODE DR.
  - DR_BASE_INSTR+i (i < NUM_DR) sets dr_sel_o[i]=1.
  - All-ones, and any unassigned code, selects the 1-bit BYPASS.
- DR path, internal registers:
  - DR_CAPTURE loads IDCODE_VALUE into the IDCODE DR, or 0 into the bypass bit.
  - DR_SHIFT shifts right with tdi_i entering at the MSB; tdo_o = bit 0.
  - Data shifted into IDCODE or BYPASS is never retained past the next capture.
- DR path, external chains:
  - Strobes follow the current state combinationally and are gated by a nonzero dr_sel_o.
  - tdo_o = dr_tdo_i[i] for the selected chain while in DR_SHIFT.
- tdo_o outside the shift states is 0.
- Strobes are mutually exclusive.
- ir_o changes only on IR_UPDATE or RESET, so dr_sel_o is stable throughout a DR scan.
- Simultaneous rst_n low and any tms value: reset wins.

Optional Feature:
SCR1_TAPC_BLD_ID_EN:
- Defined: INSTR_BLD_ID selects an internal 32-bit DR. Capture loads `SCR1_BUILD_ID; shift behaviour is identical to IDCODE.
- Undefined: INSTR_BLD_ID decodes as BYPASS and no register is instantiated.

Test Plan:
- Sync reset, then tms=0 → state_o=IDLE (1) and ir_o=1. From DR_PAUSE, five tms=1 cycles → state_o=0 and tlr_o=1.
- Path to DR_SHIFT with IR=IDCODE, shift 32 bits of tdi=0 → tdo_o sequence equals 32'hC0D1DEB1, LSB first; tdo_en_o=1 for exactly those 32 cycles.
- IR scan shifting 5'h11 → captured bits out on tdo_o are 1,0,0,0,0. After IR_UPDATE: ir_o=5'h11 and dr_sel_o=4'b0010. During the following DR scan: one dr_capture_o cycle, N dr_shift_o cycles, one dr_update_o cycle, and tdo_o tracks dr_tdo_i[1].
- IR=5'h1F, shift pattern 1,0,1,1 on tdi → tdo_o outputs 0,1,0,1 (one-cycle bypass delay); all dr_* strobes stay 0.
- IR scan to 5'h12 with rst_n pulled low mid-IR_SHIFT → next cycle state_o=0, ir_o=1, no dr_update_o pulse.
- With SCR1_TAPC_BLD_ID_EN defined, IR=2 and a 32-bit DR scan → tdo_o returns `SCR1_BUILD_ID. With the macro undefined, the same scan gives a bypass 0 followed by the delayed tdi.
